// File: rtl/pwm_pkg.sv
// Shared constants, decode tables and FSM state type for the PWM decoder.
// Table lookups are plain functions so the top stays a simple register stage.
package pwm_pkg;

  localparam int CNT_W_DEF   = 6;
  localparam int TIMEOUT_DEF = 63;
  localparam int NUM_FRE     = 4;
  localparam int NUM_DUTY    = 5;

  localparam int unsigned PERIOD_TBL [NUM_FRE] = '{5, 10, 25, 50};

  // High-time to duty-code table per frequency; a high time of 0 marks an unused slot.
  localparam int unsigned DUTY_HI [NUM_FRE][NUM_DUTY] = '{
    '{ 4,  2,  1, 0, 0},
    '{ 9,  6,  4, 2, 1},
    '{21, 14,  7, 4, 1},
    '{41, 26, 14, 6, 1}
  };
  localparam logic [2:0] DUTY_CD [NUM_FRE][NUM_DUTY] = '{
    '{3'd2, 3'd3, 3'd5, 3'd0, 3'd0},
    '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5},
    '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5},
    '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5}
  };

  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] code;
  } fre_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] code;
  } duty_t;

  function automatic fre_t fre_lookup(input logic [31:0] p);
    fre_t r;
    r = '0;
    for (int i = 0; i < NUM_FRE; i++)
      if (p == PERIOD_TBL[i]) begin
        r.hit  = 1'b1;
        r.code = 2'(i);
      end
    return r;
  endfunction

  function automatic duty_t duty_lookup(input logic [1:0] f, input logic [31:0] h);
    duty_t r;
    r = '0;
    for (int j = 0; j < NUM_DUTY; j++)
      if (DUTY_HI[f][j] != 0 && h == DUTY_HI[f][j]) begin
        r.hit  = 1'b1;
        r.code = DUTY_CD[f][j];
      end
    return r;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for the asynchronous PWM input plus rise/fall detect
// against a one-cycle delayed copy of the synchronized level.
module sync_edge (
  input  logic iClk,
  input  logic iReset_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta, r_sync, r_dly;

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_dly  <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_dly  <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_dly;
  assign o_fall  = ~r_sync & r_dly;

endmodule

// File: rtl/pwm_decoder.sv
// Measures PWM period/high time rise-to-rise, decodes them against the
// frequency/duty table and flags an input that stops toggling.
module pwm_decoder
  import pwm_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             iClk,
  input  logic             iReset_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_cnt,
  output logic [1:0]       fre_code,
  output logic [2:0]       duty_code,
  output logic             match,
  output logic             valid,
  output logic             stuck_hi,
  output logic             stuck_lo
);

  logic             w_level, w_rise, w_fall;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, r_hnext;
  logic             r_armed;
  logic             w_tmo, w_capture, w_publish;
  fre_t             w_fre;
  duty_t            w_duty;

  sync_edge u_sync (
    .iClk     (iClk),
    .iReset_n (iReset_n),
    .i_async  (pwm_in),
    .o_level  (w_level),
    .o_rise   (w_rise),
    .o_fall   (w_fall)
  );

  // Timeout fires once per quiet stretch; r_armed re-arms on every rise and
  // starts armed so a dead input after reset still raises stuck_lo.
  assign w_tmo = r_armed && (r_cnt == CNT_W'(TIMEOUT)) && !w_rise &&
                 !(r_state == ST_HIGH && w_fall);

  assign w_fre  = fre_lookup(32'(r_cnt));
  assign w_duty = duty_lookup(w_fre.code, 32'(r_hnext));

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_publish   = 1'b0;
    case (r_state)
      ST_IDLE: if (w_rise) w_state_nxt = ST_HIGH;
      ST_HIGH: begin
        if (w_fall) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_LOW;
        end else if (w_tmo) w_state_nxt = ST_IDLE;
      end
      ST_LOW: begin
        if (w_rise) begin
          w_publish   = 1'b1;
          w_state_nxt = ST_HIGH;
        end else if (w_tmo) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_cnt     <= '0;
      r_hnext   <= '0;
      r_armed   <= 1'b1;
      period    <= '0;
      high_cnt  <= '0;
      fre_code  <= '0;
      duty_code <= '0;
      match     <= 1'b0;
      valid     <= 1'b0;
      stuck_hi  <= 1'b0;
      stuck_lo  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (w_rise)                           r_cnt <= CNT_W'(1);
      else if (r_cnt != CNT_W'(TIMEOUT))    r_cnt <= r_cnt + CNT_W'(1);
      if (w_capture) r_hnext <= r_cnt;
      if (w_rise) begin
        r_armed  <= 1'b1;
        stuck_hi <= 1'b0;
        stuck_lo <= 1'b0;
      end
      if (w_publish) begin
        period   <= r_cnt;
        high_cnt <= r_hnext;
        valid    <= 1'b1;
        match    <= w_fre.hit & w_duty.hit;
        if (w_fre.hit) begin
          fre_code <= w_fre.code;
          if (w_duty.hit) duty_code <= w_duty.code;
        end
      end
      if (w_tmo) begin
        r_armed  <= 1'b0;
        stuck_hi <= w_level;
        stuck_lo <= ~w_level;
        match    <= 1'b0;
        if (w_level) duty_code <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_decoder.sv
// Randomized PWM stimulus against a rise-to-rise reference model; a monitor
// pops expected measurements whenever the decoder publishes one.
module tb_pwm_decoder;

  logic       iClk = 1'b0;
  logic       iReset_n = 1'b0;
  logic       pwm_in = 1'b0;
  logic [5:0] period, high_cnt;
  logic [1:0] fre_code;
  logic [2:0] duty_code;
  logic       match, valid, stuck_hi, stuck_lo;

  pwm_decoder #(.CNT_W(6), .TIMEOUT(63)) dut (
    .iClk      (iClk),
    .iReset_n  (iReset_n),
    .pwm_in    (pwm_in),
    .period    (period),
    .high_cnt  (high_cnt),
    .fre_code  (fre_code),
    .duty_code (duty_code),
    .match     (match),
    .valid     (valid),
    .stuck_hi  (stuck_hi),
    .stuck_lo  (stuck_lo)
  );

  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  typedef struct {
    int per; int hi; int fre; int duty; int mat; int cyc;
  } exp_t;
  exp_t q[$];

  int n_chk = 0, n_fail = 0;
  int m_fre = 0, m_duty = 0;
  bit prev_ok = 0;
  int prev_h = 0, prev_p = 0;

  int tp [18] = '{5, 5, 5, 10, 10, 10, 10, 10, 25, 25, 25, 25, 25, 50, 50, 50, 50, 50};
  int th [18] = '{4, 2, 1, 9, 6, 4, 2, 1, 21, 14, 7, 4, 1, 41, 26, 14, 6, 1};

  task automatic chk(input string nm, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic int ref_fre(input int p);
    case (p)
      5: return 0;  10: return 1;  25: return 2;  50: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int ref_duty(input int p, input int h);
    case (p)
      5:  case (h) 4: return 2; 2: return 3; 1: return 5; default: return -1; endcase
      10: case (h) 9: return 1; 6: return 2; 4: return 3; 2: return 4; 1: return 5; default: return -1; endcase
      25: case (h) 21: return 1; 14: return 2; 7: return 3; 4: return 4; 1: return 5; default: return -1; endcase
      50: case (h) 41: return 1; 26: return 2; 14: return 3; 6: return 4; 1: return 5; default: return -1; endcase
      default: return -1;
    endcase
  endfunction

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  // A rise closes the previous full period: expect it published 3 edges later.
  task automatic open_rise();
    exp_t e;
    int f, d;
    if (prev_ok) begin
      f = ref_fre(prev_p);
      d = ref_duty(prev_p, prev_h);
      if (f >= 0) m_fre = f;
      if (d >= 0) m_duty = d;
      e = '{per: prev_p, hi: prev_h, fre: m_fre, duty: m_duty,
            mat: (d >= 0) ? 1 : 0, cyc: cyc + 3};
      q.push_back(e);
    end
    pwm_in = 1'b1;
  endtask

  task automatic pulse(input int h, input int p);
    open_rise();
    repeat (h) step();
    pwm_in = 1'b0;
    repeat (p - h) step();
    prev_ok = 1;
    prev_h  = h;
    prev_p  = p;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_period"}, int'(period), 0);
    chk({tag, "_high_cnt"}, int'(high_cnt), 0);
    chk({tag, "_fre_code"}, int'(fre_code), 0);
    chk({tag, "_duty_code"}, int'(duty_code), 0);
    chk({tag, "_match"}, int'(match), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_stuck_hi"}, int'(stuck_hi), 0);
    chk({tag, "_stuck_lo"}, int'(stuck_lo), 0);
  endtask

  always @(negedge iClk) begin : mon
    exp_t e;
    if (iReset_n && valid) begin
      if (q.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        e = q.pop_front();
        chk("period", int'(period), e.per);
        chk("high_cnt", int'(high_cnt), e.hi);
        chk("fre_code", int'(fre_code), e.fre);
        chk("duty_code", int'(duty_code), e.duty);
        chk("match", int'(match), e.mat);
        chk("latency_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int idx, p, h;
    repeat (3) step();
    chk_all_zero("reset");
    iReset_n = 1'b1;

    // Dead input after reset
    repeat (70) step();
    chk("post_reset_stuck_lo", int'(stuck_lo), 1);
    chk("post_reset_stuck_hi", int'(stuck_hi), 0);

    repeat (5) pulse(6, 10);
    pulse(2, 5); pulse(1, 5); pulse(4, 5);
    for (int i = 0; i < 18; i++) pulse(th[i], tp[i]);
    pulse(5, 12); pulse(6, 10); pulse(5, 12);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1, 0) == 1) begin
        idx = $urandom_range(17, 0);
        p = tp[idx];
        h = th[idx];
      end else begin
        p = $urandom_range(60, 4);
        h = $urandom_range(p - 1, 1);
      end
      pulse(h, p);
    end

    // Input stuck high after a good measurement
    pulse(6, 10);
    open_rise();
    repeat (60) step();
    chk("stuck_hi_early", int'(stuck_hi), 0);
    repeat (7) step();
    chk("stuck_hi_set", int'(stuck_hi), 1);
    chk("stuck_lo_clear", int'(stuck_lo), 0);
    chk("stuck_duty_zero", int'(duty_code), 0);
    chk("stuck_match_zero", int'(match), 0);
    repeat (3) step();
    pwm_in = 1'b0;
    repeat (5) step();
    chk("stuck_hi_holds", int'(stuck_hi), 1);
    prev_ok = 0;
    m_duty  = 0;
    pulse(6, 10);
    chk("stuck_hi_cleared", int'(stuck_hi), 0);
    pulse(6, 10);

    // Reset in the middle of a high phase
    open_rise();
    repeat (5) step();
    iReset_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    pwm_in = 1'b0;
    repeat (5) step();
    prev_ok = 0;
    m_fre   = 0;
    m_duty  = 0;
    iReset_n = 1'b1;
    repeat (10) step();
    repeat (3) pulse(26, 50);
    open_rise();
    repeat (10) step();
    pwm_in = 1'b0;
    repeat (5) step();

    chk("all_expected_published", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
